// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - instruction/memory handshake and datapath control bundle
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7;
  logic       Zero;
  logic       mem_ready;
  logic       mem_req;
  logic       PCWrite;
  logic       AdrSrc;
  logic       IRWrite;
  logic       MemWrite;
  logic       RegWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal;
  logic [3:0] state;

  modport master (
    input  op, funct3, funct7, Zero, mem_ready,
    output mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );

  modport slave (
    output op, funct3, funct7, Zero, mem_ready,
    input  mem_req, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, ALUControl, illegal, state
  );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RISC-V control FSM with memory wait handshake
module multicycle_controller (
  input  logic                   clk,
  input  logic                   rst_n,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_e;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  // Held as a raw 4-bit vector so the unused encodings 11-15 stay observable.
  logic [3:0] state_q;

  logic       op_legal;
  logic       mem_req;
  logic       adr_src;
  logic       ir_write;
  logic       pc_write;
  logic       mem_write;
  logic       reg_write;
  logic       illegal;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] imm_src;
  logic [2:0] alu_control;

  always_comb begin
    op_legal = 1'b0;
    case (bus.op)
      OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: op_legal = 1'b1;
      default:                                  op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      case (state_q)
        FETCH:    state_q <= bus.mem_ready ? DECODE : FETCH;
        DECODE: begin
          case (bus.op)
            OP_LW, OP_SW: state_q <= MEMADR;
            OP_R:         state_q <= EXECUTER;
            OP_I:         state_q <= EXECUTEI;
            OP_BEQ:       state_q <= BEQ;
            OP_JAL:       state_q <= JAL;
            default:      state_q <= FETCH;
          endcase
        end
        MEMADR:   state_q <= bus.op[5] ? MEMWRITE : MEMREAD;
        MEMREAD:  state_q <= bus.mem_ready ? MEMWB : MEMREAD;
        MEMWRITE: state_q <= bus.mem_ready ? FETCH : MEMWRITE;
        MEMWB:    state_q <= FETCH;
        EXECUTER: state_q <= ALUWB;
        EXECUTEI: state_q <= ALUWB;
        ALUWB:    state_q <= FETCH;
        BEQ:      state_q <= FETCH;
        JAL:      state_q <= ALUWB;
        default:  state_q <= FETCH;
      endcase
    end
  end

  // Strobes qualified by mem_ready/Zero must follow the current cycle, so outputs decode from state_q.
  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    case (state_q)
      FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = bus.mem_ready;
        pc_write   = bus.mem_ready;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        illegal   = ~op_legal;
      end
      MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
      end
      MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      MEMWRITE: begin
        mem_req   = 1'b1;
        adr_src   = 1'b1;
        mem_write = bus.mem_ready;
      end
      MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      EXECUTER: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
      end
      EXECUTEI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
      end
      ALUWB: reg_write = 1'b1;
      BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        pc_write  = bus.Zero;
      end
      JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_src = 2'b00;
    case (bus.op)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    alu_control = 3'b000;
    case (alu_op)
      2'b01: alu_control = 3'b001;
      2'b10: begin
        case (bus.funct3)
          3'b000:  alu_control = (bus.op[5] & bus.funct7) ? 3'b001 : 3'b000;
          3'b010:  alu_control = 3'b101;
          3'b110:  alu_control = 3'b011;
          3'b111:  alu_control = 3'b010;
          default: alu_control = 3'b000;
        endcase
      end
      default: alu_control = 3'b000;
    endcase
  end

  // Enables are forced low while reset is held, even though FETCH would otherwise strobe them.
  assign bus.mem_req    = mem_req;
  assign bus.AdrSrc     = adr_src;
  assign bus.IRWrite    = ir_write & rst_n;
  assign bus.PCWrite    = pc_write & rst_n;
  assign bus.MemWrite   = mem_write & rst_n;
  assign bus.RegWrite   = reg_write & rst_n;
  assign bus.illegal    = illegal & rst_n;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ImmSrc     = imm_src;
  assign bus.ALUControl = alu_control;
  assign bus.state      = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - directed scoreboard bench for multicycle_controller
module tb_multicycle_controller;

  logic clk;
  logic rst_n;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [21:0] exp_q [$];

  logic [6:0] t_op;
  logic [2:0] t_f3;
  logic       t_f7;
  logic       t_z;
  logic       t_mr;

  // Flag order: {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, illegal}
  function automatic logic [21:0] ev(input logic [3:0] st, input logic [6:0] flags,
                                     input logic [1:0] rs, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [1:0] imm,
                                     input logic [2:0] aluc);
    return {st, flags, rs, sa, sb, imm, aluc};
  endfunction

  function automatic logic [21:0] observed();
    return {bus.state, bus.mem_req, bus.AdrSrc, bus.IRWrite, bus.PCWrite, bus.MemWrite,
            bus.RegWrite, bus.illegal, bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB,
            bus.ImmSrc, bus.ALUControl};
  endfunction

  task automatic check(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_assert++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [21:0] exp);
    bus.op        = t_op;
    bus.funct3    = t_f3;
    bus.funct7    = t_f7;
    bus.Zero      = t_z;
    bus.mem_ready = t_mr;
    exp_q.push_back(exp);
    @(negedge clk);
    check(tag, observed(), exp_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input string tag, input logic [1:0] imm);
    cyc({tag, "_fetch"}, ev(4'd0, 7'b1011000, 2'b10, 2'b00, 2'b10, imm, 3'b000));
  endtask

  task automatic do_decode(input string tag, input logic [1:0] imm);
    cyc({tag, "_decode"}, ev(4'd1, 7'b0000000, 2'b00, 2'b01, 2'b01, imm, 3'b000));
  endtask

  logic [6:0] a_op   [4] = '{7'b0110011, 7'b0110011, 7'b0010011, 7'b0010011};
  logic [2:0] a_f3   [4] = '{3'b111, 3'b010, 3'b000, 3'b110};
  logic       a_f7   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic [3:0] a_st   [4] = '{4'd6, 4'd6, 4'd7, 4'd7};
  logic [1:0] a_sb   [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
  logic [2:0] a_aluc [4] = '{3'b010, 3'b101, 3'b000, 3'b011};

  initial begin
    rst_n = 1'b0;
    t_op = 7'b0000011; t_f3 = 3'b010; t_f7 = 1'b0; t_z = 1'b0; t_mr = 1'b1;
    bus.op = t_op; bus.funct3 = t_f3; bus.funct7 = t_f7; bus.Zero = t_z; bus.mem_ready = t_mr;

    #2;
    check("reset_state_enables",
          {12'd0, bus.state, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.illegal}, 22'd0);
    @(posedge clk);
    #1;
    check("reset_after_edge",
          {12'd0, bus.state, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.illegal}, 22'd0);
    rst_n = 1'b1;

    // lw with memory always ready
    do_fetch("lw", 2'b00);
    do_decode("lw", 2'b00);
    cyc("lw_memadr",  ev(4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    cyc("lw_memread", ev(4'd3, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    cyc("lw_memwb",   ev(4'd4, 7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000));

    // sw with a stalled fetch and three write wait cycles
    t_op = 7'b0100011; t_mr = 1'b0;
    cyc("sw_fetch_wait", ev(4'd0, 7'b1000000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000));
    t_mr = 1'b1;
    do_fetch("sw", 2'b01);
    do_decode("sw", 2'b01);
    cyc("sw_memadr", ev(4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000));
    t_mr = 1'b0;
    for (int i = 0; i < 3; i++)
      cyc($sformatf("sw_wait%0d", i), ev(4'd5, 7'b1100000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));
    t_mr = 1'b1;
    cyc("sw_write", ev(4'd5, 7'b1100100, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000));

    // R-type sub
    t_op = 7'b0110011; t_f3 = 3'b000; t_f7 = 1'b1;
    do_fetch("sub", 2'b00);
    do_decode("sub", 2'b00);
    cyc("sub_exec",  ev(4'd6, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001));
    cyc("sub_aluwb", ev(4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));

    // ALU decode across R and I forms, including funct7 set on an I-type add
    for (int k = 0; k < 4; k++) begin
      t_op = a_op[k]; t_f3 = a_f3[k]; t_f7 = a_f7[k];
      do_fetch($sformatf("alu%0d", k), 2'b00);
      do_decode($sformatf("alu%0d", k), 2'b00);
      cyc($sformatf("alu%0d_exec", k), ev(a_st[k], 7'b0000000, 2'b00, 2'b10, a_sb[k], 2'b00, a_aluc[k]));
      cyc($sformatf("alu%0d_aluwb", k), ev(4'd8, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000));
    end

    // beq taken then not taken
    t_op = 7'b1100011; t_f3 = 3'b000; t_f7 = 1'b0; t_z = 1'b1;
    do_fetch("beq1", 2'b10);
    do_decode("beq1", 2'b10);
    cyc("beq1_beq", ev(4'd9, 7'b0001000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));
    t_z = 1'b0;
    do_fetch("beq0", 2'b10);
    do_decode("beq0", 2'b10);
    cyc("beq0_beq", ev(4'd9, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001));

    // jal
    t_op = 7'b1101111;
    do_fetch("jal", 2'b11);
    do_decode("jal", 2'b11);
    cyc("jal_jal",   ev(4'd10, 7'b0001000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000));
    cyc("jal_aluwb", ev(4'd8,  7'b0000010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000));

    // illegal opcode
    t_op = 7'b1111111;
    do_fetch("ill", 2'b00);
    cyc("ill_decode", ev(4'd1, 7'b0000001, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000));
    t_mr = 1'b0;
    cyc("ill_refetch", ev(4'd0, 7'b1000000, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000));
    t_mr = 1'b1;

    // async reset in the middle of a stalled load
    t_op = 7'b0000011; t_f3 = 3'b010;
    do_fetch("rst", 2'b00);
    do_decode("rst", 2'b00);
    cyc("rst_memadr", ev(4'd2, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000));
    bus.mem_ready = 1'b0;
    #2;
    check("rst_in_memread", {18'd0, bus.state}, 22'd3);
    rst_n = 1'b0;
    #1;
    check("rst_async_state", {18'd0, bus.state}, 22'd0);
    check("rst_async_enables",
          {17'd0, bus.PCWrite, bus.IRWrite, bus.MemWrite, bus.RegWrite, bus.illegal}, 22'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    t_mr = 1'b1;
    do_fetch("post_rst", 2'b00);
    do_decode("post_rst", 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 op  input  7  opcode from instruction register.
REQ-004 funct3  input  3  funct3 from instruction register.
REQ-005 funct7  input  1  instruction bit 30.
REQ-006 Zero  input  1  ALU zero flag, sampled in BEQ state.
REQ-007 mem_ready  input  1  memory completes the access requested this cycle.
REQ-008 mem_req  output  1  memory access request.
REQ-009 PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite  output  1 each  datapath enables and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  output  2 each  datapath selects.
REQ-011 ALUControl  output  3  ALU operation.
REQ-012 illegal  output  1  one-cycle pulse for an unsupported opcode.
REQ-013 state  output  4  current FSM state, for debug.

Function
REQ-014 Control SHALL be a Moore FSM with 11 states, encoded 0-10: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
REQ-015 FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; then go to DECODE. If mem_ready=0, stay in FETCH.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by op:
- 0000011 or 0100011 -> MEMADR
- 0110011 -> EXECUTER
- 0010011 -> EXECUTEI
- 1100011 -> BEQ
- 1101111 -> JAL
- any other op -> FETCH, with illegal=1 for that cycle.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00; next state MEMREAD if op[5]=0, else MEMWRITE.
REQ-018 MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00; stay until mem_ready=1, then go to MEMWB.
REQ-019 MEMWRITE: mem_req=1, AdrSrc=1; MemWrite=1 only in the cycle mem_ready=1, then go to FETCH; otherwise stay.
REQ-020 MEMWB: ResultSrc=01, RegWrite=1; then go to FETCH.
REQ-021 EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10; then go to ALUWB.
REQ-022 EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10; then go to ALUWB.
REQ-023 ALUWB: ResultSrc=00, RegWrite=1; then go to FETCH.
REQ-024 BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00; PCWrite=Zero; then go to FETCH.
REQ-025 JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1; then go to ALUWB.
REQ-026 Any output not listed for a state SHALL be 0.
REQ-027 ImmSrc SHALL be decoded combinationally from op in every state:
- 0100011 -> 01
- 1100011 -> 10
- 1101111 -> 11
- all others -> 00
REQ-028 ALUControl SHALL be decoded combinationally from the internal 2-bit ALUOp:
- ALUOp 00 -> 000 (add)
- ALUOp 01 -> 001 (sub)
- ALUOp 10 by funct3:
  - 000 -> 001 if op[5]&funct7, else 000
  - 010 -> 101 (slt)
  - 110 -> 011 (or)
  - 111 -> 010 (and)
  - any other -> 000
REQ-029 An access SHALL be held for any number of wait cycles. During waits, mem_req and the address select stay stable, and no write enable is asserted.
REQ-030 Unreachable encodings 11-15 SHALL transition to FETCH on the next edge, with all outputs 0.

Reset
REQ-031 When rst_n=0, state SHALL become FETCH immediately, independent of clk, including mid-access.
REQ-032 While rst_n=0, PCWrite, IRWrite, MemWrite, RegWrite and illegal SHALL be 0.
REQ-033 The first rising edge after rst_n deasserts SHALL evaluate FETCH normally.

Verification
REQ-034 lw (op=0000011), mem_ready=1 always:
- states FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles)
- RegWrite=1 only in MEMWB, with ResultSrc=01.
REQ-035 sw (op=0100011), mem_ready low for 3 cycles in MEMWRITE:
- state stays MEMWRITE for 4 cycles
- MemWrite=1 exactly once, in the 4th cycle, then FETCH.
REQ-036 R-type sub (op=0110011, funct3=000, funct7=1):
- ALUControl=001 in EXECUTER
- RegWrite=1 in ALUWB; total 4 cycles.
REQ-037 beq with Zero=1, then with Zero=0:
- PCWrite=1 in BEQ for the first, 0 for the second
- ALUControl=001 in both.
REQ-038 Illegal op 1111111: DECODE pulses illegal=1 for one cycle, then FETCH, with no write enables asserted.
REQ-039 rst_n pulled low mid-MEMREAD, between clock edges:
- state reads 0 (FETCH) before the next edge
- RegWrite=0.
